decode_stage: RTL and testbench

Instruction-decode stage of the five-stage pipeline CPU, sitting between fetch and execute and directly upstream of the register file's read ports. It holds the IF/ID pipeline register, drives the register-file read addresses, and resolves operand hazards. It forwards from EX, MEM and WB, and stalls one cycle on load-use. Resolved operands are latched into the ID/EX pipeline register, which the execute stage consumes.

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage
// Instruction-decode stage of the five-stage RV32I pipeline. Holds the IF/ID
// pipeline register, drives the register-file read addresses, resolves source
// operands by forwarding from EX, MEM and WB, detects load-use hazards (one
// cycle stall) and latches the resolved instruction into the ID/EX register.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_valid/if_pc/if_inst   instruction presented by fetch
//   flush                    redirect from EX, kills IF/ID and ID/EX
//   stall                    load-use stall, fetch holds PC and if_*
//   rR1/rR2, rD1/rD2         register-file read address / data
//   ex_result                ALU result of the instruction in EX
//   mem_we/mem_rd/mem_wd     MEM-stage write-back info (forwarding source)
//   wb_we/wb_rd/wb_wd        WB-stage write-back info (forwarding source)
//   ex_*                     ID/EX pipeline register contents
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        flush,
    output logic        stall,
    output logic [4:0]  rR1,
    output logic [4:0]  rR2,
    input  logic [31:0] rD1,
    input  logic [31:0] rD2,
    input  logic [31:0] ex_result,
    input  logic        mem_we,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_wd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [4:0]  ex_rd,
    output logic        ex_rf_we,
    output logic        ex_is_load
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // IF/ID register
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    // ID/EX register
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_inst_q, ex_inst_d;
    logic [31:0] ex_rs1_val_q, ex_rs1_val_d;
    logic [31:0] ex_rs2_val_q, ex_rs2_val_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_rf_we_q, ex_rf_we_d;
    logic        ex_is_load_q, ex_is_load_d;

    logic        uses_rs1_s, uses_rs2_s, writes_rd_s, is_load_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic        ex_fwd_ok_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic        stall_s;

    // Priority forwarding: x0, then EX (non-load), then MEM, then WB, then RF.
    // WB must be forwarded because the register file only commits at the edge.
    function automatic logic [31:0] resolve_operand(
        input logic [4:0]  rs,
        input logic [31:0] rf_val,
        input logic        ex_ok,
        input logic [4:0]  ex_dst,
        input logic [31:0] ex_val,
        input logic        m_we,
        input logic [4:0]  m_dst,
        input logic [31:0] m_val,
        input logic        w_we,
        input logic [4:0]  w_dst,
        input logic [31:0] w_val
    );
        logic [31:0] res;
        if (rs == 5'd0) begin
            res = 32'd0;
        end else if (ex_ok && (ex_dst == rs)) begin
            res = ex_val;
        end else if (m_we && (m_dst == rs)) begin
            res = m_val;
        end else if (w_we && (w_dst == rs)) begin
            res = w_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    assign rs1_s = id_inst_q[19:15];
    assign rs2_s = id_inst_q[24:20];
    assign rd_s  = id_inst_q[11:7];

    // Opcode classification of the instruction held in IF/ID.
    always_comb begin
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        is_load_s   = 1'b0;
        case (id_inst_q[6:0])
            OPC_OP:     begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; writes_rd_s = 1'b1; end
            OPC_OP_IMM: begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
            OPC_LOAD:   begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; is_load_s = 1'b1; end
            OPC_STORE:  begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_BRANCH: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_JALR:   begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
            OPC_JAL, OPC_LUI, OPC_AUIPC: begin writes_rd_s = 1'b1; end
            default:    begin uses_rs1_s = 1'b0; end
        endcase
    end

    // A load in EX cannot forward yet; it is the stall case instead.
    assign ex_fwd_ok_s = ex_valid_q & ex_rf_we_q & ~ex_is_load_q;

    // Operand resolution for both sources.
    always_comb begin
        rs1_val_s = resolve_operand(rs1_s, rD1, ex_fwd_ok_s, ex_rd_q, ex_result,
                                    mem_we, mem_rd, mem_wd, wb_we, wb_rd, wb_wd);
        rs2_val_s = resolve_operand(rs2_s, rD2, ex_fwd_ok_s, ex_rd_q, ex_result,
                                    mem_we, mem_rd, mem_wd, wb_we, wb_rd, wb_wd);
    end

    // Load-use hazard; suppressed while a flush kills the instruction anyway.
    always_comb begin
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = id_valid_q & ex_valid_q & ex_is_load_q & ex_rf_we_q &
                      ((uses_rs1_s & (rs1_s == ex_rd_q)) |
                       (uses_rs2_s & (rs2_s == ex_rd_q)));
        end
    end

    // Next-state of both pipeline registers: flush > stall > advance.
    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        ex_valid_d   = 1'b0;
        ex_pc_d      = 32'd0;
        ex_inst_d    = 32'd0;
        ex_rs1_val_d = 32'd0;
        ex_rs2_val_d = 32'd0;
        ex_rd_d      = 5'd0;
        ex_rf_we_d   = 1'b0;
        ex_is_load_d = 1'b0;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (stall_s) begin
            // IF/ID holds, ID/EX takes the bubble set up by the defaults
            id_valid_d = id_valid_q;
        end else begin
            id_valid_d   = if_valid;
            id_pc_d      = if_pc;
            id_inst_d    = if_inst;
            ex_valid_d   = id_valid_q;
            ex_pc_d      = id_pc_q;
            ex_inst_d    = id_inst_q;
            ex_rs1_val_d = rs1_val_s;
            ex_rs2_val_d = rs2_val_s;
            ex_rd_d      = rd_s;
            ex_rf_we_d   = id_valid_q & writes_rd_s & (rd_s != 5'd0);
            ex_is_load_d = id_valid_q & is_load_s;
        end
    end

    // Pipeline register storage with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'd0;
            id_inst_q    <= 32'd0;
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= 32'd0;
            ex_inst_q    <= 32'd0;
            ex_rs1_val_q <= 32'd0;
            ex_rs2_val_q <= 32'd0;
            ex_rd_q      <= 5'd0;
            ex_rf_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_inst_q    <= ex_inst_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_rd_q      <= ex_rd_d;
            ex_rf_we_q   <= ex_rf_we_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign stall      = stall_s;
    assign rR1        = rs1_s;
    assign rR2        = rs2_s;
    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_inst    = ex_inst_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rf_we   = ex_rf_we_q;
    assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the pipeline rules.
module tb_decode_stage;

    logic        clk, rst, if_valid, flush, stall;
    logic [31:0] if_pc, if_inst, rD1, rD2, ex_result, mem_wd, wb_wd;
    logic [4:0]  rR1, rR2, mem_rd, wb_rd, ex_rd;
    logic        mem_we, wb_we, ex_valid, ex_rf_we, ex_is_load;
    logic [31:0] ex_pc, ex_inst, ex_rs1_val, ex_rs2_val;

    int checks = 0;
    int failures = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .flush(flush), .stall(stall), .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
        .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
        .ex_is_load(ex_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] u_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pipe();
        if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0; flush = 1'b0;
        mem_we = 1'b0; wb_we = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0;
        tick();
        tick();
    endtask

    // After this, i1 sits in ID/EX and i2 in IF/ID.
    task automatic load_pair(input logic [31:0] i1, input logic [31:0] p1,
                             input logic [31:0] i2, input logic [31:0] p2);
        if_valid = 1'b1; if_pc = p1; if_inst = i1;
        tick();
        if_pc = p2; if_inst = i2;
        tick();
        if_valid = 1'b0; if_inst = 32'd0;
    endtask

    // ---------------- reference model ----------------
    logic        m_id_valid;
    logic [31:0] m_id_pc, m_id_inst;
    logic        m_ex_valid, m_ex_we, m_ex_ld;
    logic [31:0] m_ex_pc, m_ex_inst, m_ex_v1, m_ex_v2;
    logic [4:0]  m_ex_rd;

    // {uses rs1, uses rs2, writes rd, is load}
    function automatic logic [3:0] op_class(input logic [6:0] op);
        case (op)
            7'b0110011: return 4'b1110;
            7'b0010011: return 4'b1010;
            7'b0000011: return 4'b1011;
            7'b0100011: return 4'b1100;
            7'b1100011: return 4'b1100;
            7'b1100111: return 4'b1010;
            7'b1101111, 7'b0110111, 7'b0010111: return 4'b0010;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (m_ex_valid && m_ex_we && !m_ex_ld && m_ex_rd == rs) return ex_result;
        if (mem_we && mem_rd == rs) return mem_wd;
        if (wb_we && wb_rd == rs) return wb_wd;
        return rf;
    endfunction

    // ---------------- directed tests ----------------
    task automatic test_reset();
        checks++;
        if ({ex_valid, ex_rf_we, ex_is_load, stall} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {ex_valid, ex_rf_we, ex_is_load, stall});
        end
        checks++;
        if ({ex_pc, ex_inst, ex_rs1_val, ex_rs2_val, ex_rd} !== 133'd0) begin
            failures++; $display("FAIL reset_fields got pc=%h inst=%h v1=%h v2=%h rd=%0d exp=0",
                                 ex_pc, ex_inst, ex_rs1_val, ex_rs2_val, ex_rd);
        end
        rD1 = 32'hDEAD; rD2 = 32'hDEAD;
        tick(); tick();
        checks++;
        if ({ex_valid, ex_rs1_val, ex_pc} !== 65'd0) begin
            failures++; $display("FAIL reset_idle got valid=%b v1=%h pc=%h exp=0", ex_valid, ex_rs1_val, ex_pc);
        end
        // Fill the pipe, then reset asynchronously mid-cycle.
        load_pair(i_addi(5'd5, 5'd0, 12'd7), 32'h40, i_addi(5'd6, 5'd0, 12'd1), 32'h44);
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h40) begin
            failures++; $display("FAIL prereset_valid got valid=%b pc=%h exp 1/00000040", ex_valid, ex_pc);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({ex_valid, ex_rf_we, ex_pc, ex_inst, ex_rd, stall} !== 72'd0) begin
            failures++; $display("FAIL async_reset got valid=%b we=%b pc=%h inst=%h rd=%0d stall=%b exp=0",
                                 ex_valid, ex_rf_we, ex_pc, ex_inst, ex_rd, stall);
        end
        tick();
        rst = 1'b0;
        // First valid output only on the second edge after the first if_valid.
        if_valid = 1'b1; if_pc = 32'h80; if_inst = i_addi(5'd1, 5'd0, 12'd3);
        tick();
        if_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL latency_edge1 got ex_valid=%b exp=0", ex_valid);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h80) begin
            failures++; $display("FAIL latency_edge2 got valid=%b pc=%h exp 1/00000080", ex_valid, ex_pc);
        end
    endtask

    task automatic test_ex_forward();
        idle_pipe();
        rD1 = 32'h1234; rD2 = 32'h1234;
        load_pair(i_addi(5'd5, 5'd0, 12'd7), 32'h100, r_add(5'd6, 5'd5, 5'd5), 32'h104);
        checks++;
        if (ex_rf_we !== 1'b1 || ex_rd !== 5'd5) begin
            failures++; $display("FAIL addi_decode got we=%b rd=%0d exp 1/5", ex_rf_we, ex_rd);
        end
        ex_result = 32'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL ex_fwd_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (ex_rs1_val !== 32'd7 || ex_rs2_val !== 32'd7 || ex_pc !== 32'h104) begin
            failures++; $display("FAIL ex_forward got v1=%h v2=%h pc=%h exp 7/7/104", ex_rs1_val, ex_rs2_val, ex_pc);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_val [3];
        exp_val[0] = 32'd1; exp_val[1] = 32'd2; exp_val[2] = 32'd3;
        for (int k = 0; k < 3; k++) begin
            idle_pipe();
            // k=0: EX targets x3; otherwise EX targets x4
            load_pair(i_addi((k == 0) ? 5'd3 : 5'd4, 5'd0, 12'd1), 32'h200,
                      r_add(5'd10, 5'd3, 5'd0), 32'h204);
            ex_result = 32'd1;
            mem_we = (k < 2); mem_rd = 5'd3; mem_wd = 32'd2;
            wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'd3;
            rD1 = 32'd9; rD2 = 32'd9;
            tick();
            checks++;
            if (ex_rs1_val !== exp_val[k] || ex_rs2_val !== 32'd0) begin
                failures++; $display("FAIL priority_%0d got v1=%h v2=%h exp %h/0", k, ex_rs1_val, ex_rs2_val, exp_val[k]);
            end
        end
    endtask

    task automatic test_load_use();
        idle_pipe();
        load_pair(i_lw(5'd4, 5'd1), 32'h300, r_add(5'd7, 5'd4, 5'd2), 32'h304);
        if_valid = 1'b1; if_pc = 32'h308; if_inst = i_addi(5'd1, 5'd1, 12'd1);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL loaduse_stall got=%b exp=1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_rf_we !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL loaduse_bubble got valid=%b we=%b stall=%b exp 0/0/0", ex_valid, ex_rf_we, stall);
        end
        mem_we = 1'b1; mem_rd = 5'd4; mem_wd = 32'h55;
        rD1 = 32'h11; rD2 = 32'h22;
        tick();
        if_valid = 1'b0; mem_we = 1'b0;
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h304 || ex_rs1_val !== 32'h55 || ex_rs2_val !== 32'h22) begin
            failures++; $display("FAIL loaduse_issue got valid=%b pc=%h v1=%h v2=%h exp 1/304/55/22",
                                 ex_valid, ex_pc, ex_rs1_val, ex_rs2_val);
        end
    endtask

    task automatic test_x0_and_nonusers();
        idle_pipe();
        wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'hFFFF;
        rD1 = 32'h77; rD2 = 32'h77;
        load_pair(i_addi(5'd0, 5'd0, 12'd5), 32'h400, r_add(5'd8, 5'd0, 5'd0), 32'h404);
        checks++;
        if (ex_valid !== 1'b1 || ex_rf_we !== 1'b0) begin
            failures++; $display("FAIL x0_rf_we got valid=%b we=%b exp 1/0", ex_valid, ex_rf_we);
        end
        tick();
        checks++;
        if (ex_rs1_val !== 32'd0 || ex_rs2_val !== 32'd0 || ex_rf_we !== 1'b1) begin
            failures++; $display("FAIL x0_operands got v1=%h v2=%h we=%b exp 0/0/1", ex_rs1_val, ex_rs2_val, ex_rf_we);
        end
        idle_pipe();
        load_pair(i_lw(5'd9, 5'd1), 32'h410, u_lui(5'd9, 20'hABCDE), 32'h414);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL lui_after_lw got stall=%b exp=0", stall);
        end
    endtask

    task automatic test_flush_with_stall();
        idle_pipe();
        load_pair(i_lw(5'd4, 5'd1), 32'h500, r_add(5'd7, 5'd4, 5'd2), 32'h504);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL flush_masks_stall got=%b exp=0", stall);
        end
        if_valid = 1'b1; if_pc = 32'h508; if_inst = i_addi(5'd2, 5'd0, 12'd2);
        tick();
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL flush_kill got valid=%b stall=%b exp 0/0", ex_valid, stall);
        end
        if_pc = 32'h600; if_inst = i_addi(5'd11, 5'd0, 12'd1);
        tick();
        if_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL flush_id_killed got ex_valid=%b exp=0", ex_valid);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h600 || ex_rd !== 5'd11) begin
            failures++; $display("FAIL flush_restart got valid=%b pc=%h rd=%0d exp 1/600/11", ex_valid, ex_pc, ex_rd);
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [6:0] ops [10];
        logic [3:0] c;
        logic       e_stall;
        logic       n_id_valid, n_ex_valid, n_we, n_ld;
        logic [31:0] n_id_pc, n_id_inst, n_ex_pc, n_ex_inst, n_v1, n_v2;
        logic [4:0] n_rd;
        int         errs;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};
        if_valid = 1'b0; flush = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        m_id_valid = 1'b0; m_id_pc = 32'd0; m_id_inst = 32'd0;
        m_ex_valid = 1'b0; m_ex_we = 1'b0; m_ex_ld = 1'b0; m_ex_pc = 32'd0;
        m_ex_inst = 32'd0; m_ex_v1 = 32'd0; m_ex_v2 = 32'd0; m_ex_rd = 5'd0;
        errs = 0;
        for (int i = 0; i < 500; i++) begin
            if_valid  = ($urandom_range(0, 3) != 0);
            if_pc     = $urandom;
            if_inst   = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
            flush     = ($urandom_range(0, 15) == 0);
            rD1 = $urandom; rD2 = $urandom; ex_result = $urandom;
            mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_wd = $urandom;
            wb_we  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_wd  = $urandom;
            #1;
            c = op_class(m_id_inst[6:0]);
            e_stall = !flush && m_id_valid && m_ex_valid && m_ex_ld && m_ex_we &&
                      ((c[3] && m_id_inst[19:15] == m_ex_rd) || (c[2] && m_id_inst[24:20] == m_ex_rd));
            checks++;
            if (stall !== e_stall) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_stall cyc=%0d got=%b exp=%b", i, stall, e_stall);
            end
            if (m_id_valid) begin
                checks++;
                if (rR1 !== m_id_inst[19:15] || rR2 !== m_id_inst[24:20]) begin
                    failures++; errs++;
                    if (errs < 10) $display("FAIL rand_raddr cyc=%0d got=%0d/%0d exp=%0d/%0d",
                                            i, rR1, rR2, m_id_inst[19:15], m_id_inst[24:20]);
                end
            end
            // Model: what the pipeline should hold after this edge.
            n_id_valid = m_id_valid; n_id_pc = m_id_pc; n_id_inst = m_id_inst;
            n_ex_valid = 1'b0; n_we = 1'b0; n_ld = 1'b0;
            n_ex_pc = m_ex_pc; n_ex_inst = m_ex_inst; n_v1 = m_ex_v1; n_v2 = m_ex_v2; n_rd = m_ex_rd;
            if (flush) begin
                n_id_valid = 1'b0;
            end else if (!e_stall) begin
                n_id_valid = if_valid; n_id_pc = if_pc; n_id_inst = if_inst;
                n_ex_valid = m_id_valid;
                n_ex_pc = m_id_pc; n_ex_inst = m_id_inst; n_rd = m_id_inst[11:7];
                n_v1 = ref_operand(m_id_inst[19:15], rD1);
                n_v2 = ref_operand(m_id_inst[24:20], rD2);
                n_we = m_id_valid && c[1] && (m_id_inst[11:7] != 5'd0);
                n_ld = m_id_valid && c[0];
            end
            @(posedge clk);
            #1;
            m_id_valid = n_id_valid; m_id_pc = n_id_pc; m_id_inst = n_id_inst;
            m_ex_valid = n_ex_valid; m_ex_we = n_we; m_ex_ld = n_ld; m_ex_pc = n_ex_pc;
            m_ex_inst = n_ex_inst; m_ex_v1 = n_v1; m_ex_v2 = n_v2; m_ex_rd = n_rd;
            checks++;
            if (ex_valid !== m_ex_valid || ex_rf_we !== m_ex_we) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_flags cyc=%0d got v=%b we=%b exp v=%b we=%b",
                                        i, ex_valid, ex_rf_we, m_ex_valid, m_ex_we);
            end
            if (m_ex_valid) begin
                checks++;
                if (ex_pc !== m_ex_pc || ex_inst !== m_ex_inst || ex_rd !== m_ex_rd ||
                    ex_rs1_val !== m_ex_v1 || ex_rs2_val !== m_ex_v2 || ex_is_load !== m_ex_ld) begin
                    failures++; errs++;
                    if (errs < 10) $display("FAIL rand_fields cyc=%0d got pc=%h v1=%h v2=%h rd=%0d ld=%b exp pc=%h v1=%h v2=%h rd=%0d ld=%b",
                                            i, ex_pc, ex_rs1_val, ex_rs2_val, ex_rd, ex_is_load,
                                            m_ex_pc, m_ex_v1, m_ex_v2, m_ex_rd, m_ex_ld);
                end
            end
        end
        flush = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0;
        rD1 = 32'd0; rD2 = 32'd0; ex_result = 32'd0;
        mem_we = 1'b0; mem_rd = 5'd0; mem_wd = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_x0_and_nonusers();
        test_flush_with_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
